hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Parametrised, stateful successor to the pipeline hazard unit for the 5-stage RISC-V core.
- Keeps operand forwarding, load-use stalls and branch flushes.
- Adds configurable extra load-latency bubbles, a multi-cycle mul/div busy handshake, and saturating stall/flush performance counters.
- Sits beside the datapath; drives the F/D/E/M pipeline-register enables and clears.

Parameters:
REG_ADDR_W, 5, register-address width (register 0 is hardwired zero)
LOAD_EXTRA, 0, extra bubble cycles after a load-use stall (0..15); models slower data memory
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
Rs1D, Rs2D  in  REG_ADDR_W  source registers in Decode
Rs1E, Rs2E  in  REG_ADDR_W  source registers in Execute
RdE, RdM, RdW  in  REG_ADDR_W  destination registers in E/M/W
RegWriteM, RegWriteW  in  1  register-write enables in M/W
PCSrcE  in  1  taken branch/jump resolved in E
ResultSrcE0  in  1  load instruction in E
MdStartE  in  1  mul/div instruction in E, first cycle
MdDone  in  1  mul/div unit result ready (single-cycle pulse)
ForwardAE, ForwardBE  out  2  operand mux select: 00 register file, 01 WB result, 10 ALU result in M
StallF, StallD, StallE  out  1  hold the PC, IF/ID and ID/EX registers
FlushD, FlushE, FlushM  out  1  clear the IF/ID, ID/EX and EX/MEM registers
StallCount  out  CNT_W  cycles with StallF=1
FlushCount  out  CNT_W  cycles with PCSrcE=1

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset:
  - state goes to RUN; the wait counter and both performance counters go to 0.
  - While reset is high, all stall and flush outputs are 0 and both forward selects are 00.
- Forwarding (combinational, all states):
  - Select 10 if Rs1E==RdM, RegWriteM=1 and Rs1E!=0.
  - Otherwise select 01 if Rs1E==RdW, RegWriteW=1 and Rs1E!=0.
  - Otherwise select 00.
  - M has priority over W. ForwardBE uses the same rules with Rs2E.
- lwHit = ResultSrcE0 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE). Destination register 0 never stalls.
- FSM states: RUN, LOAD_WAIT, MD_BUSY.
- RUN:
  - FlushD = PCSrcE.
  - FlushE = PCSrcE | lwHit.
  - StallF = StallD = lwHit.
  - StallE = FlushM = 0.
  - If lwHit and LOAD_EXTRA>0: next state LOAD_WAIT, wait counter loaded with LOAD_EXTRA.
  - If MdStartE: next state MD_BUSY; no stall is issued this cycle.
- LOAD_WAIT:
  - StallF = StallD = FlushE = 1; all other stall/flush outputs 0.
  - The wait counter decrements each cycle.
  - Leave for RUN after the cycle in which the counter equals 1, so LOAD_WAIT lasts exactly LOAD_EXTRA cycles.
  - Total stall for a load-use hazard is 1+LOAD_EXTRA cycles.
- MD_BUSY:
  - StallF = StallD = StallE = FlushM = 1; FlushD = FlushE = 0.
  - On the cycle MdDone=1, all four outputs are 0 and next state is RUN. The instruction advances that cycle.
  - A MdDone seen in RUN or LOAD_WAIT is ignored.
- PCSrcE, ResultSrcE0 and MdStartE describe the single instruction in E, so at most one is high in any cycle; a violation is a bench assertion error.
- Counters:
  - StallCount increments each cycle StallF=1.
  - FlushCount increments each cycle PCSrcE=1 and state is RUN.
  - Both counters saturate at all-ones and do not wrap.
- Reset asserted in LOAD_WAIT or MD_BUSY aborts immediately: RUN and counters 0 on the next edge.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - hz_state_t enum: RUN, LOAD_WAIT, MD_BUSY.
  - Constant ZERO_REG = 0.
- One sub-module, fwd_sel: single-operand forwarding comparator, instantiated twice (A and B).

Test Plan:
- Forward priority: Rs1E=5, RdM=5, RdW=5, RegWriteM=RegWriteW=1 -> ForwardAE=10. Repeat with RegWriteM=0 -> 01. Rs2E=0 with RdM=0, RegWriteM=1 -> ForwardBE=00.
- Load-use, LOAD_EXTRA=0: ResultSrcE0=1, RdE=7, Rs2D=7 -> one cycle of StallF=StallD=FlushE=1, then free; StallCount=1. Same stimulus with RdE=0 -> no stall.
- Load-use, LOAD_EXTRA=2: same stimulus -> StallF=1 for exactly 3 consecutive cycles, FlushE=1 in all 3; StallCount=3.
- Mul/div: MdStartE pulse, MdDone 4 cycles later -> StallF/D/E=FlushM=1 for 4 cycles, all 0 on the MdDone cycle, state RUN next.
- Branch: PCSrcE=1 for one cycle -> FlushD=FlushE=1 that cycle only, StallF=0; FlushCount=1. With CNT_W=4 and 20 branches -> FlushCount=15 (saturated).
- Reset mid-op: assert reset in the 2nd MD_BUSY cycle -> all stall/flush outputs 0 that cycle, StallCount=0 and state RUN after the edge; a late MdDone is ignored.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    LOAD_WAIT = 2'b01,
    MD_BUSY   = 2'b10
  } hz_state_t;

  localparam int ZERO_REG = 0;

endpackage

// File: rtl/fwd_sel.sv
// Single-operand forwarding comparator: picks the youngest in-flight writer of rs.
// Purely combinational; M stage wins over W stage, register 0 never forwards.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rdm,
  input  logic [REG_ADDR_W-1:0] rdw,
  input  logic                  regwritem,
  input  logic                  regwritew,
  output logic [1:0]            sel
);

  fwd_sel_t sel_e;
  logic     rs_live;

  assign rs_live = (rs != REG_ADDR_W'(ZERO_REG));

  always_comb begin
    sel_e = FWD_RF;
    if (rs_live && regwritem && (rs == rdm)) begin
      sel_e = FWD_MEM;
    end else if (rs_live && regwritew && (rs == rdw)) begin
      sel_e = FWD_WB;
    end
  end

  assign sel = sel_e;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: forwarding, load-use stalls with optional
// extra bubbles, mul/div busy stalls, branch flushes and saturating perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_EXTRA = 0,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  PCSrcE,
  input  logic                  ResultSrcE0,
  input  logic                  MdStartE,
  input  logic                  MdDone,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic [CNT_W-1:0]      StallCount,
  output logic [CNT_W-1:0]      FlushCount
);

  hz_state_t  state, state_nxt;
  logic [3:0] wait_cnt, wait_nxt;
  logic       lw_hit;
  logic [1:0] fwd_a, fwd_b;

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs(Rs1E), .rdm(RdM), .rdw(RdW),
    .regwritem(RegWriteM), .regwritew(RegWriteW), .sel(fwd_a)
  );

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs(Rs2E), .rdm(RdM), .rdw(RdW),
    .regwritem(RegWriteM), .regwritew(RegWriteW), .sel(fwd_b)
  );

  assign ForwardAE = reset ? 2'b00 : fwd_a;
  assign ForwardBE = reset ? 2'b00 : fwd_b;

  assign lw_hit = ResultSrcE0 && (RdE != REG_ADDR_W'(ZERO_REG)) &&
                  ((Rs1D == RdE) || (Rs2D == RdE));

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    case (state)
      RUN: begin
        FlushD = PCSrcE;
        FlushE = PCSrcE | lw_hit;
        StallF = lw_hit;
        StallD = lw_hit;
        if (lw_hit && (LOAD_EXTRA > 0)) begin
          state_nxt = LOAD_WAIT;
          wait_nxt  = 4'(LOAD_EXTRA);
        end else if (MdStartE) begin
          state_nxt = MD_BUSY;
        end
      end
      LOAD_WAIT: begin
        StallF   = 1'b1;
        StallD   = 1'b1;
        FlushE   = 1'b1;
        wait_nxt = wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) state_nxt = RUN;
      end
      MD_BUSY: begin
        // The instruction in E advances on the MdDone cycle itself.
        if (MdDone) begin
          state_nxt = RUN;
        end else begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          FlushM = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
    if (reset) begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushM = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      wait_cnt   <= 4'd0;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (StallF && (StallCount != '1)) StallCount <= StallCount + CNT_W'(1);
      if (PCSrcE && (state == RUN) && (FlushCount != '1)) FlushCount <= FlushCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench: two controllers (LOAD_EXTRA=0/CNT_W=4 and LOAD_EXTRA=2/CNT_W=32)
// share stimulus; a behavioural model queues expected outputs, a monitor compares.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic       rwm, rww, pcsrc, ld, mdstart, mddone;

  logic [1:0]  fa0, fb0, fa2, fb2;
  logic        sf0, sd0, se0, fd0, fe0, fm0;
  logic        sf2, sd2, se2, fd2, fe2, fm2;
  logic [3:0]  sc0, fc0;
  logic [31:0] sc2, fc2;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(5), .LOAD_EXTRA(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .Rs1D(rs1d), .Rs2D(rs2d), .Rs1E(rs1e), .Rs2E(rs2e),
    .RdE(rde), .RdM(rdm), .RdW(rdw), .RegWriteM(rwm), .RegWriteW(rww),
    .PCSrcE(pcsrc), .ResultSrcE0(ld), .MdStartE(mdstart), .MdDone(mddone),
    .ForwardAE(fa0), .ForwardBE(fb0), .StallF(sf0), .StallD(sd0), .StallE(se0),
    .FlushD(fd0), .FlushE(fe0), .FlushM(fm0), .StallCount(sc0), .FlushCount(fc0)
  );

  hazard_ctrl #(.REG_ADDR_W(5), .LOAD_EXTRA(2), .CNT_W(32)) dut2 (
    .clk(clk), .reset(reset), .Rs1D(rs1d), .Rs2D(rs2d), .Rs1E(rs1e), .Rs2E(rs2e),
    .RdE(rde), .RdM(rdm), .RdW(rdw), .RegWriteM(rwm), .RegWriteW(rww),
    .PCSrcE(pcsrc), .ResultSrcE0(ld), .MdStartE(mdstart), .MdDone(mddone),
    .ForwardAE(fa2), .ForwardBE(fb2), .StallF(sf2), .StallD(sd2), .StallE(se2),
    .FlushD(fd2), .FlushE(fe2), .FlushM(fm2), .StallCount(sc2), .FlushCount(fc2)
  );

  typedef struct {
    logic [1:0] fa;
    logic [1:0] fb;
    logic [5:0] ctl;   // {StallF, StallD, StallE, FlushD, FlushE, FlushM}
    longint     sc;
    longint     fc;
    bit         cnt_ok;
  } exp_t;

  exp_t q0[$], q2[$];
  int   npass = 0, ntot = 0;

  // Reference model state, index 0 -> dut0, index 1 -> dut2.
  int     extra[2] = '{0, 2};
  longint cmax[2]  = '{15, 64'hFFFF_FFFF};
  int     ld_left[2];
  bit     md_busy[2];
  longint sc_m[2], fc_m[2];
  bit     known = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [1:0] fwd_of(input logic [4:0] r);
    if (r != 0 && rwm && r == rdm) return 2'b10;
    if (r != 0 && rww && r == rdw) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t model_step(input int m);
    exp_t e;
    bit sf, sd, se, fd, fe, fm, in_run, lw;
    {sf, sd, se, fd, fe, fm} = 6'b0;
    in_run   = 1'b0;
    e.fa     = fwd_of(rs1e);
    e.fb     = fwd_of(rs2e);
    e.sc     = sc_m[m];
    e.fc     = fc_m[m];
    e.cnt_ok = known;
    if (reset) begin
      e.fa = 2'b00;
      e.fb = 2'b00;
      ld_left[m] = 0;
      md_busy[m] = 1'b0;
      sc_m[m]    = 0;
      fc_m[m]    = 0;
    end else begin
      if (md_busy[m]) begin
        if (mddone) md_busy[m] = 1'b0;
        else {sf, sd, se, fm} = 4'hF;
      end else if (ld_left[m] > 0) begin
        sf = 1'b1; sd = 1'b1; fe = 1'b1;
        ld_left[m]--;
      end else begin
        in_run = 1'b1;
        lw = ld && rde != 0 && (rs1d == rde || rs2d == rde);
        fd = pcsrc;
        fe = pcsrc | lw;
        sf = lw;
        sd = lw;
        if (lw) ld_left[m] = extra[m];
        if (mdstart) md_busy[m] = 1'b1;
      end
      if (sf && sc_m[m] < cmax[m]) sc_m[m]++;
      if (in_run && pcsrc && fc_m[m] < cmax[m]) fc_m[m]++;
    end
    e.ctl = {sf, sd, se, fd, fe, fm};
    return e;
  endfunction

  // Queue this cycle's expectations, then move to just after the next active edge.
  task automatic issue();
    q0.push_back(model_step(0));
    q2.push_back(model_step(1));
    if (reset) known = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pcsrc = 0; ld = 0; mdstart = 0; mddone = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    assert ($countones({pcsrc, ld, mdstart}) <= 1)
      else $error("more than one of PCSrcE/ResultSrcE0/MdStartE high");
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("dut0_fwdA", 64'(fa0), 64'(e.fa));
      chk("dut0_fwdB", 64'(fb0), 64'(e.fb));
      chk("dut0_ctl", 64'({sf0, sd0, se0, fd0, fe0, fm0}), 64'(e.ctl));
      if (e.cnt_ok) begin
        chk("dut0_stallcnt", 64'(sc0), e.sc);
        chk("dut0_flushcnt", 64'(fc0), e.fc);
      end
    end
    if (q2.size() > 0) begin
      e = q2.pop_front();
      chk("dut2_fwdA", 64'(fa2), 64'(e.fa));
      chk("dut2_fwdB", 64'(fb2), 64'(e.fb));
      chk("dut2_ctl", 64'({sf2, sd2, se2, fd2, fe2, fm2}), 64'(e.ctl));
      if (e.cnt_ok) begin
        chk("dut2_stallcnt", 64'(sc2), e.sc);
        chk("dut2_flushcnt", 64'(fc2), e.fc);
      end
    end
  end

  initial begin
    int r, kind;
    reset = 1; idle();
    {rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw} = '0;
    rwm = 0; rww = 0;
    @(posedge clk); #1;
    issue(); issue();
    reset = 0;
    issue();

    // Forwarding priority and register-0 exclusion
    rs1e = 5; rdm = 5; rdw = 5; rwm = 1; rww = 1; issue();
    rwm = 0; issue();
    rs2e = 0; rdm = 0; rwm = 1; issue();
    {rs1e, rs2e, rdm, rdw} = '0; rwm = 0; rww = 0;

    // Load-use on Rs2D, then the same with RdE = 0
    ld = 1; rde = 7; rs2d = 7; issue();
    idle(); repeat (4) issue();
    chk("lu_stallcnt0", 64'(sc0), 64'd1);
    chk("lu_stallcnt2", 64'(sc2), 64'd3);
    ld = 1; rde = 0; rs2d = 0; issue();
    idle(); repeat (3) issue();
    chk("lu_x0_stallcnt0", 64'(sc0), 64'd1);
    chk("lu_x0_stallcnt2", 64'(sc2), 64'd3);

    // Mul/div with MdDone four busy cycles after the start
    mdstart = 1; issue();
    idle(); repeat (4) issue();
    mddone = 1; issue();
    idle(); repeat (2) issue();
    chk("md_stallcnt0", 64'(sc0), 64'd5);
    chk("md_stallcnt2", 64'(sc2), 64'd7);

    // Branches: 4-bit counter saturates, 32-bit counter does not
    for (int i = 0; i < 20; i++) begin
      pcsrc = 1; issue();
      pcsrc = 0; issue();
    end
    chk("br_flushcnt0_sat", 64'(fc0), 64'd15);
    chk("br_flushcnt2", 64'(fc2), 64'd20);

    // Reset during the second MD_BUSY cycle, then a stale MdDone
    mdstart = 1; issue();
    idle(); issue();
    reset = 1; issue();
    reset = 0; issue();
    chk("rst_stallcnt0", 64'(sc0), 64'd0);
    chk("rst_stallcnt2", 64'(sc2), 64'd0);
    mddone = 1; issue();
    idle(); issue();
    chk("late_done_stallcnt2", 64'(sc2), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      reset = (r < 2);
      idle();
      kind = $urandom_range(0, 9);
      if (kind < 2) pcsrc = 1;
      else if (kind < 4) ld = 1;
      else if (kind == 4) mdstart = 1;
      mddone = ($urandom_range(0, 4) == 0);
      rs1d = 5'($urandom_range(0, 7)); rs2d = 5'($urandom_range(0, 7));
      rs1e = 5'($urandom_range(0, 7)); rs2e = 5'($urandom_range(0, 7));
      rde  = 5'($urandom_range(0, 7)); rdm  = 5'($urandom_range(0, 7));
      rdw  = 5'($urandom_range(0, 7));
      rwm  = 1'($urandom_range(0, 1)); rww  = 1'($urandom_range(0, 1));
      issue();
    end
    reset = 0; idle();
    issue(); issue();

    for (int i = 0; i < 10 && (q0.size() > 0 || q2.size() > 0); i++) @(posedge clk);
    if (q0.size() > 0 || q2.size() > 0) chk("scoreboard_drain", 64'(q0.size() + q2.size()), 64'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
